// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and in-order load responses onto the
// single register-file write port and tracks outstanding load destinations.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_wdata,
    input  logic            ld_issue_valid,
    input  logic [4:0]      ld_issue_rd,
    output logic            ld_issue_ready,
    input  logic            ld_resp_valid,
    input  logic [XLEN-1:0] ld_resp_data,
    output logic            ld_resp_ready,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic            rf_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [4:0]    tag_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   sb;
    logic [31:0]   sb_next;
    logic          full;
    logic          empty;
    logic          issue_fire;
    logic          resp_fire;
    logic [4:0]    head_tag;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign head_tag = tag_mem[rd_ptr];

    // Issue readiness uses the pre-edge scoreboard, so an rd retiring this cycle stays blocked.
    assign ld_issue_ready = !full && !((ld_issue_rd != 5'd0) && sb[ld_issue_rd]);
    assign ld_resp_ready  = !empty && !alu_valid;
    assign issue_fire     = ld_issue_valid && ld_issue_ready;
    assign resp_fire      = ld_resp_valid && ld_resp_ready;

    assign hazard = sb[chk_rs1] | sb[chk_rs2] | sb[chk_rd];

    always_comb begin
        sb_next = sb;
        if (resp_fire) begin
            sb_next[head_tag] = 1'b0;
        end
        if (issue_fire && (ld_issue_rd != 5'd0)) begin
            sb_next[ld_issue_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            sb <= sb_next;
            if (issue_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (resp_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({issue_fire, resp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            tag_mem[wr_ptr] <= ld_issue_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (alu_valid) begin
            rf_en    <= (alu_rd != 5'd0);
            rf_rd    <= alu_rd;
            rf_wdata <= alu_wdata;
        end else if (resp_fire) begin
            rf_en    <= (head_tag != 5'd0);
            rf_rd    <= head_tag;
            rf_wdata <= ld_resp_data;
        end else begin
            rf_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: expected writes are queued as stimulus is
// driven and popped when the registered write port produces them.
module tb_wb_arbiter;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wdata;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        ld_resp_ready;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    wr_t        exp_q[$];
    logic [4:0] tag_q[$];
    int         total = 0;
    int         bad = 0;

    wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
        .ld_issue_ready(ld_issue_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .ld_resp_ready(ld_resp_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alu_valid      = 1'b0;
        alu_rd         = 5'd0;
        alu_wdata      = 32'h0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = 5'd0;
        ld_resp_valid  = 1'b0;
        ld_resp_data   = 32'h0;
        chk_rs1        = 5'd0;
        chk_rs2        = 5'd0;
        chk_rd         = 5'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_valid      = 1'($urandom);
            alu_rd         = 5'($urandom);
            alu_wdata      = $urandom;
            ld_issue_valid = 1'($urandom);
            ld_issue_rd    = 5'($urandom);
            ld_resp_valid  = 1'($urandom);
            ld_resp_data   = $urandom;
            chk_rs1        = 5'($urandom);
            chk_rs2        = 5'($urandom);
            chk_rd         = 5'($urandom);
            tick();
        end
        idle();
        #2 rst_n = 1'b1;
        #1;
        total++; if (rf_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_rf_en: got %0b want 0", rf_en); end
        total++; if (rf_rd !== 5'd0) begin bad++; $display("[TB] FAIL reset_rf_rd: got %0d want 0", rf_rd); end
        total++; if (rf_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
        total++; if (hazard !== 1'b0) begin bad++; $display("[TB] FAIL reset_hazard: got %0b want 0", hazard); end
        total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_issue_ready: got %0b want 1", ld_issue_ready); end
        total++; if (ld_resp_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_ready: got %0b want 0", ld_resp_ready); end
    endtask

    task automatic test_alu_write;
        wr_t e;
        logic [4:0]  rds [2]  = '{5'd5, 5'd0};
        logic [31:0] dats [2] = '{32'hDEADBEEF, 32'h1111_2222};
        for (int i = 0; i < 2; i++) begin
            idle();
            alu_valid = 1'b1;
            alu_rd    = rds[i];
            alu_wdata = dats[i];
            exp_q.push_back('{en: (rds[i] != 5'd0), rd: rds[i], data: dats[i]});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({rf_en, rf_rd, rf_wdata} !== e) begin
                bad++;
                $display("[TB] FAIL alu_write%0d: got en=%0b rd=%0d data=%h want en=%0b rd=%0d data=%h",
                         i, rf_en, rf_rd, rf_wdata, e.en, e.rd, e.data);
            end
        end
        idle();
        tick();
        total++;
        if ({rf_en, rf_rd, rf_wdata} !== {1'b0, 5'd0, 32'h1111_2222}) begin
            bad++;
            $display("[TB] FAIL alu_hold: got en=%0b rd=%0d data=%h want en=0 rd=0 data=11112222",
                     rf_en, rf_rd, rf_wdata);
        end
    endtask

    task automatic test_load_roundtrip;
        wr_t e;
        idle();
        ld_issue_valid = 1'b1;
        ld_issue_rd    = 5'd7;
        #1;
        total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL rt_issue_ready: got %0b want 1", ld_issue_ready); end
        tag_q.push_back(5'd7);
        tick();
        idle();
        chk_rs1 = 5'd7;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("[TB] FAIL rt_hazard_set: got %0b want 1", hazard); end
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'h12345678;
        #1;
        total++; if (ld_resp_ready !== 1'b1) begin bad++; $display("[TB] FAIL rt_resp_ready: got %0b want 1", ld_resp_ready); end
        begin
            logic [4:0] t;
            t = tag_q.pop_front();
            exp_q.push_back('{en: (t != 5'd0), rd: t, data: 32'h12345678});
        end
        tick();
        idle();
        chk_rs1 = 5'd7;
        #1;
        e = exp_q.pop_front();
        total++;
        if ({rf_en, rf_rd, rf_wdata} !== e) begin
            bad++;
            $display("[TB] FAIL rt_write: got en=%0b rd=%0d data=%h want en=%0b rd=%0d data=%h",
                     rf_en, rf_rd, rf_wdata, e.en, e.rd, e.data);
        end
        total++; if (hazard !== 1'b0) begin bad++; $display("[TB] FAIL rt_hazard_clear: got %0b want 0", hazard); end
    endtask

    task automatic test_priority;
        wr_t e;
        logic [4:0] t;
        idle();
        ld_issue_valid = 1'b1;
        ld_issue_rd    = 5'd3;
        tag_q.push_back(5'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            ld_resp_valid = 1'b1;
            ld_resp_data  = 32'h3333_0003;
            if (i < 2) begin
                alu_valid = 1'b1;
                alu_rd    = 5'd4;
                alu_wdata = 32'hA000_0000 + 32'(i);
                exp_q.push_back('{en: 1'b1, rd: 5'd4, data: 32'hA000_0000 + 32'(i)});
            end else begin
                t = tag_q.pop_front();
                exp_q.push_back('{en: (t != 5'd0), rd: t, data: 32'h3333_0003});
            end
            #1;
            total++;
            if (ld_resp_ready !== (i == 2)) begin
                bad++;
                $display("[TB] FAIL prio_resp_ready%0d: got %0b want %0b", i, ld_resp_ready, (i == 2));
            end
            tick();
            e = exp_q.pop_front();
            total++;
            if ({rf_en, rf_rd, rf_wdata} !== e) begin
                bad++;
                $display("[TB] FAIL prio_write%0d: got en=%0b rd=%0d data=%h want en=%0b rd=%0d data=%h",
                         i, rf_en, rf_rd, rf_wdata, e.en, e.rd, e.data);
            end
        end
    endtask

    task automatic test_full_waw;
        wr_t e;
        logic [4:0] t;
        logic [4:0] probe [3] = '{5'd5, 5'd0, 5'd1};
        for (int i = 1; i <= 4; i++) begin
            idle();
            ld_issue_valid = 1'b1;
            ld_issue_rd    = 5'(i);
            #1;
            total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_ready%0d: got %0b want 1", i, ld_issue_ready); end
            tag_q.push_back(5'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            ld_issue_rd = probe[i];
            #1;
            total++; if (ld_issue_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready_rd%0d: got %0b want 0", probe[i], ld_issue_ready); end
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            ld_resp_valid = 1'b1;
            ld_resp_data  = 32'h0000_0100 + 32'(i);
            t = tag_q.pop_front();
            exp_q.push_back('{en: (t != 5'd0), rd: t, data: 32'h0000_0100 + 32'(i)});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({rf_en, rf_rd, rf_wdata} !== e) begin
                bad++;
                $display("[TB] FAIL drain_write%0d: got en=%0b rd=%0d data=%h want en=%0b rd=%0d data=%h",
                         i, rf_en, rf_rd, rf_wdata, e.en, e.rd, e.data);
            end
        end
        // WAW: second load to x9 stays blocked until the first response retires
        idle();
        ld_issue_valid = 1'b1;
        ld_issue_rd    = 5'd9;
        tag_q.push_back(5'd9);
        tick();
        #1;
        total++; if (ld_issue_ready !== 1'b0) begin bad++; $display("[TB] FAIL waw_block: got %0b want 0", ld_issue_ready); end
        tick();
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'h0909_0909;
        #1;
        total++; if (ld_issue_ready !== 1'b0) begin bad++; $display("[TB] FAIL waw_same_cycle: got %0b want 0", ld_issue_ready); end
        t = tag_q.pop_front();
        exp_q.push_back('{en: (t != 5'd0), rd: t, data: 32'h0909_0909});
        tick();
        ld_resp_valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        total++;
        if ({rf_en, rf_rd, rf_wdata} !== e) begin
            bad++;
            $display("[TB] FAIL waw_write: got en=%0b rd=%0d data=%h want en=%0b rd=%0d data=%h",
                     rf_en, rf_rd, rf_wdata, e.en, e.rd, e.data);
        end
        total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL waw_release: got %0b want 1", ld_issue_ready); end
        tag_q.push_back(5'd9);
        tick();
        idle();
        ld_resp_valid = 1'b1;
        ld_resp_data  = 32'h9999_0000;
        t = tag_q.pop_front();
        exp_q.push_back('{en: (t != 5'd0), rd: t, data: 32'h9999_0000});
        tick();
        e = exp_q.pop_front();
        total++;
        if ({rf_en, rf_rd, rf_wdata} !== e) begin
            bad++;
            $display("[TB] FAIL waw_reissue_write: got en=%0b rd=%0d data=%h want en=%0b rd=%0d data=%h",
                     rf_en, rf_rd, rf_wdata, e.en, e.rd, e.data);
        end
        idle();
    endtask

    task automatic test_back_to_back;
        wr_t e;
        logic [4:0] t;
        for (int i = 0; i <= 10; i++) begin
            idle();
            if (i < 10) begin
                ld_issue_valid = 1'b1;
                ld_issue_rd    = (i % 2 == 0) ? 5'd0 : 5'd8;
            end
            if (i > 0) begin
                ld_resp_valid = 1'b1;
                ld_resp_data  = 32'hC000_0000 + 32'(i);
            end
            #1;
            if (i > 0) begin
                total++;
                if (ld_resp_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_resp_ready%0d: got %0b want 1", i, ld_resp_ready); end
                t = tag_q.pop_front();
                exp_q.push_back('{en: (t != 5'd0), rd: t, data: 32'hC000_0000 + 32'(i)});
            end
            if (i < 10) begin
                total++;
                if (ld_issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_issue_ready%0d: got %0b want 1", i, ld_issue_ready); end
                tag_q.push_back(ld_issue_rd);
            end
            tick();
            if (i > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({rf_en, rf_rd, rf_wdata} !== e) begin
                    bad++;
                    $display("[TB] FAIL b2b_write%0d: got en=%0b rd=%0d data=%h want en=%0b rd=%0d data=%h",
                             i, rf_en, rf_rd, rf_wdata, e.en, e.rd, e.data);
                end
            end else begin
                total++;
                if (rf_en !== 1'b0) begin bad++; $display("[TB] FAIL b2b_first_idle: got %0b want 0", rf_en); end
            end
        end
        idle();
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 3; i++) begin
            idle();
            ld_issue_valid = 1'b1;
            ld_issue_rd    = 5'(10 + i);
            if (i == 2) begin
                alu_valid = 1'b1;
                alu_rd    = 5'd2;
                alu_wdata = 32'h2222_2222;
            end
            tag_q.push_back(5'(10 + i));
            tick();
        end
        idle();
        chk_rs1 = 5'd10;
        chk_rd  = 5'd12;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("[TB] FAIL mid_hazard_before: got %0b want 1", hazard); end
        total++; if (rf_en !== 1'b1) begin bad++; $display("[TB] FAIL mid_rf_en_before: got %0b want 1", rf_en); end
        rst_n = 1'b0;
        tag_q.delete();
        exp_q.delete();
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("[TB] FAIL mid_hazard_after: got %0b want 0", hazard); end
        total++; if (rf_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_rf_en_after: got %0b want 0", rf_en); end
        total++; if (ld_resp_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_resp_ready_after: got %0b want 0", ld_resp_ready); end
        #1 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        test_reset();
        test_alu_write();
        test_load_roundtrip();
        test_priority();
        test_full_waw();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back side of the 32x32 register file: sole producer of its write port (rf_en, rd, wdata).
- Merges single-cycle ALU results with variable-latency, in-order load responses onto the one write port.
- Keeps a per-register scoreboard of outstanding load destinations and gives decode combinational RAW/WAW hazard flags.
- Sits between execute/LSU and the register file; outputs are registered and launched at posedge, so the negedge register-file write lands mid-cycle.

Parameters:
- DEPTH, 4, maximum outstanding loads (tag FIFO entries); power of two, ≥2.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock, all state on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- alu_valid  input  1  ALU result to write this cycle.
- alu_rd  input  5  ALU destination.
- alu_wdata  input  XLEN  ALU result.
- ld_issue_valid  input  1  load issued to LSU.
- ld_issue_rd  input  5  load destination.
- ld_issue_ready  output  1  load may issue this cycle.
- ld_resp_valid  input  1  LSU returning load data, in issue order.
- ld_resp_data  input  XLEN  load data.
- ld_resp_ready  output  1  response accepted this cycle.
- chk_rs1  input  5  decode source 1.
- chk_rs2  input  5  decode source 2.
- chk_rd  input  5  decode destination.
- hazard  output  1  any checked register has a pending load.
- rf_en  output  1  register-file write enable (registered).
- rf_rd  output  5  register-file write address (registered).
- rf_wdata  output  XLEN  register-file write data (registered).

Behaviour:

Reset:
- rst_n low clears immediately: scoreboard all 0, tag FIFO empty (count 0, pointers 0), rf_en=0, rf_rd=0, rf_wdata=0.
- Reset mid-operation discards all outstanding tags; the LSU is reset by the same rst_n.

Tag FIFO:
- DEPTH entries of 5-bit rd; wr_ptr and rd_ptr wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Full means count==DEPTH; empty means count==0.

Issue path:
- ld_issue_ready = !full && !(ld_issue_rd!=0 && sb[ld_issue_rd]); combinational from current state.
- This enforces at most one outstanding load per nonzero rd.
- A handshake (valid && ready) pushes ld_issue_rd and sets sb[ld_issue_rd] at the edge, unless rd==0.
- Loads to x0 still occupy a tag slot.

Response path:
- ld_resp_ready = !empty && !alu_valid. The ALU has strict priority; a load response waits while alu_valid=1.
- An accepted response pops the head tag and clears that tag's sb bit at the edge.
- Simultaneous push and pop in one cycle: count is unchanged, both pointers advance.
- Issue to an rd whose response is accepted in the same cycle is still blocked that cycle, because ready uses the pre-edge sb.

Write port (latency 1):
- At posedge: if alu_valid, then rf_en=(alu_rd!=0), rf_rd=alu_rd, rf_wdata=alu_wdata.
- Else if a response is accepted, rf_en=(head_tag!=0), rf_rd=head_tag, rf_wdata=ld_resp_data.
- Else rf_en=0; rf_rd and rf_wdata hold their previous values.
- x0 is never written.
- ALU write to a pending rd is illegal; decode prevents it through hazard (WAW), and no check is made here.

Hazard:
- hazard = sb[chk_rs1] | sb[chk_rs2] | sb[chk_rd], with sb[0] hardwired 0. Purely combinational.
- A cleared bit drops hazard in the same cycle rf_en=1 for that rd; the negedge write makes the value visible before the next posedge.

Test Plan:
- Reset: hold rst_n=0 with random inputs, release -> rf_en=0, rf_rd=0, rf_wdata=0, hazard=0, ld_issue_ready=1, ld_resp_ready=0.
- ALU write: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle rf_en=1, rf_rd=5, rf_wdata=0xDEADBEEF. Same with rd=0 -> rf_en=0.
- Load round-trip: issue rd=7, then chk_rs1=7 -> hazard=1. Respond 0x12345678 -> ld_resp_ready=1; next cycle rf_en=1, rf_rd=7, rf_wdata=0x12345678, hazard=0.
- Priority: response pending (rd=3) while alu_valid=1 with rd=4 for 2 cycles -> ld_resp_ready=0 both cycles, writes to x4. Third cycle alu_valid=0 -> response accepted, x3 written next cycle.
- Full and WAW blocking: issue rd=1..4 (DEPTH=4) -> ld_issue_ready=0 for any rd. Separately, with rd=9 pending, issuing rd=9 -> ready=0 until its response is accepted, then 1.
- Wrap and simultaneity: 10 back-to-back loads with one response per cycle, alternating rd 0 and 8 -> every response is accepted; rf_en=0 for the x0 tags; tags return in issue order; count never exceeds 2.
- Mid-operation reset: assert rst_n=0 with 3 tags outstanding -> hazard=0 and rf_en=0 immediately, without waiting for a clock edge.
